// File: rtl/bin_bcd_seg_seq.sv
// Iterative double-dabble binary-to-BCD converter with 7-segment outputs.
// One input bit per clock; the results update only when done pulses.
module bin_bcd_seg_seq #(
    parameter int IN       = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN-1:0]         bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN + 1);
    localparam logic [CW-1:0] LAST = CW'(IN - 1);

    // 10^n, saturated at 2^IN so the compare stays IN+1 bits wide
    function automatic logic [IN:0] pow10_sat(input int n);
        logic [IN:0]   sat;
        logic [IN:0]   v;
        logic [IN+4:0] w;
        sat = '0;
        sat[IN] = 1'b1;
        v = '0;
        v[0] = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = {4'd0, v} * 10;
            if (w >= {4'd0, sat}) v = sat;
            else v = w[IN:0];
        end
        return v;
    endfunction

    localparam logic [IN:0] LIM = pow10_sat(DIGITS);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [IN-1:0]    sh;
    logic [BW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             ovf_pend;

    logic [BW-1:0]    adj;
    logic [BW+IN-1:0] cat;
    logic [BW-1:0]    acc_n;
    logic [IN-1:0]    sh_n;
    logic [7*DIGITS-1:0] seg_n;
    logic [3:0]       d;
    logic             nz;

    always_comb begin
        adj = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k+:4] >= 4'd5) adj[4*k+:4] = acc[4*k+:4] + 4'd3;
        end
        cat   = {adj, sh} << 1;
        acc_n = cat[BW+IN-1:IN];
        sh_n  = cat[IN-1:0];
        // Blank from the top down until the first nonzero digit
        seg_n = '0;
        nz    = 1'b0;
        d     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            d  = acc_n[4*k+:4];
            nz = nz | (d != 4'd0);
            if (BLANK_LZ != 0 && !ovf_pend && !nz && k != 0)
                seg_n[7*k+:7] = 7'b1111111;
            else
                seg_n[7*k+:7] = seg7(d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd_out  <= '0;
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                seg_out[7*k+:7] <= (k == 0 || BLANK_LZ == 0) ?
                                   7'b0000001 : 7'b1111111;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh       <= bin_in;
                        acc      <= '0;
                        cnt      <= '0;
                        ovf_pend <= ({1'b0, bin_in} >= LIM);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_n;
                    sh  <= sh_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bcd_out  <= acc_n;
                        seg_out  <= seg_n;
                        overflow <= ovf_pend;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_bcd_seg_seq.sv
// Directed bench for bin_bcd_seg_seq: an 8-bit blanking instance
// and a 10-bit non-blanking instance sharing clock and reset.
module tb_bin_bcd_seg_seq;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111, S9 = 7'b0000100;
    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        start8 = 1'b0, busy8, done8, ovf8;
    logic [7:0]  bin8 = '0;
    logic [11:0] bcd8;
    logic [20:0] seg8;

    logic        start10 = 1'b0, busy10, done10, ovf10;
    logic [9:0]  bin10 = '0;
    logic [11:0] bcd10;
    logic [20:0] seg10;

    int tests = 0;
    int fails = 0;
    int n, n2;
    bit seen;

    always #5 clk = ~clk;

    bin_bcd_seg_seq #(.IN(8), .DIGITS(3), .BLANK_LZ(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .overflow(ovf8),
        .bcd_out(bcd8), .seg_out(seg8)
    );

    bin_bcd_seg_seq #(.IN(10), .DIGITS(3), .BLANK_LZ(0)) u10 (
        .clk(clk), .rst(rst), .start(start10), .bin_in(bin10),
        .busy(busy10), .done(done10), .overflow(ovf10),
        .bcd_out(bcd10), .seg_out(seg10)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Counts cycles until the selected done is seen (bounded)
    task automatic wait_done(input bit w, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if ((w ? done10 : done8) === 1'b1) break;
        end
    endtask

    task automatic conv(input bit w, input logic [9:0] v, output int cyc);
        @(negedge clk);
        if (w) begin bin10 = v; start10 = 1'b1; end
        else begin bin8 = v[7:0]; start8 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        start10 = 1'b0;
        chk("busy_after_start", {31'd0, w ? busy10 : busy8}, 32'd1);
        wait_done(w, cyc);
    endtask

    initial begin
        #12;
        chk("rst_bcd8", {20'd0, bcd8}, 32'h000);
        chk("rst_seg8", {11'd0, seg8}, {11'd0, BL, BL, S0});
        chk("rst_busy_done8", {30'd0, busy8, done8}, 32'd0);
        chk("rst_seg10", {11'd0, seg10}, {11'd0, S0, S0, S0});
        @(negedge clk);
        rst = 1'b1;

        conv(0, 10'd255, n);
        chk("lat_255", n, 8);
        chk("busy_at_done", {31'd0, busy8}, 32'd0);
        chk("bcd_255", {20'd0, bcd8}, 32'h255);
        chk("seg_255", {11'd0, seg8}, {11'd0, S2, S5, S5});
        chk("ovf_255", {31'd0, ovf8}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done8}, 32'd0);

        conv(0, 10'd7, n);
        chk("bcd_7", {20'd0, bcd8}, 32'h007);
        chk("seg_7", {11'd0, seg8}, {11'd0, BL, BL, S7});
        conv(0, 10'd100, n);
        chk("bcd_100", {20'd0, bcd8}, 32'h100);
        chk("seg_100", {11'd0, seg8}, {11'd0, S1, S0, S0});

        conv(1, 10'd999, n);
        chk("lat_999", n, 10);
        chk("bcd_999", {20'd0, bcd10}, 32'h999);
        chk("ovf_999", {31'd0, ovf10}, 32'd0);
        chk("seg_999", {11'd0, seg10}, {11'd0, S9, S9, S9});
        conv(1, 10'd1023, n);
        chk("bcd_1023", {20'd0, bcd10}, 32'h023);
        chk("ovf_1023", {31'd0, ovf10}, 32'd1);
        chk("seg_1023", {11'd0, seg10}, {11'd0, S0, S2, S3});

        // start held high across a whole conversion and the next
        @(negedge clk);
        bin8 = 8'd42;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bin8 = 8'd99;
        wait_done(0, n);
        chk("b2b_lat1", n, 8);
        chk("bcd_42", {20'd0, bcd8}, 32'h042);
        chk("seg_42", {11'd0, seg8}, {11'd0, BL, S4, S2});
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_busy", {31'd0, busy8}, 32'd1);
        repeat (3) @(negedge clk);
        chk("hold_mid_conv", {20'd0, bcd8}, 32'h042);
        wait_done(0, n2);
        chk("b2b_lat2", n2 + 4, 9);
        chk("bcd_99", {20'd0, bcd8}, 32'h099);
        chk("seg_99", {11'd0, seg8}, {11'd0, BL, S9, S9});

        // reset in the middle of a conversion
        @(negedge clk);
        bin8 = 8'd200;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
        chk("mid_rst_bcd", {20'd0, bcd8}, 32'h000);
        chk("mid_rst_seg", {11'd0, seg8}, {11'd0, BL, BL, S0});
        chk("mid_rst_ovf10", {31'd0, ovf10}, 32'd0);
        chk("mid_rst_seg10", {11'd0, seg10}, {11'd0, S0, S0, S0});
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
        end
        chk("no_done_after_rst", {31'd0, seen}, 32'd0);
        conv(0, 10'd200, n);
        chk("lat_200", n, 8);
        chk("bcd_200", {20'd0, bcd8}, 32'h200);
        chk("seg_200", {11'd0, seg8}, {11'd0, S2, S0, S0});

        conv(1, 10'd5, n);
        chk("bcd10_5", {20'd0, bcd10}, 32'h005);
        chk("seg10_5_noblank", {11'd0, seg10}, {11'd0, S0, S0, S5});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bin_bcd_seg_seq.md
Name: bin_bcd_seg_seq

Overview:
Sequential, parametrised binary-to-BCD converter with 7-segment outputs for DIGITS display digits. It uses iterative double-dabble (shift-and-add-3), one bit per clock, instead of combinational %/÷ arithmetic, so it scales to wide inputs. It sits between datapath results and the board HEX displays. Behaviour added over the combinational form: a start/busy/done handshake, any digit count, leading-zero blanking, and overflow indication.

Parameters:
IN, 8, binary input width (≥1)
DIGITS, 3, number of BCD digits and 7-seg displays (≥1)
BLANK_LZ, 1, 1 = blank leading zero digits; 0 = show all digits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  conversion request; sampled only in IDLE
bin_in  input  IN  unsigned binary value; captured on the accepting edge
busy  output  1  high while conversion is in progress
done  output  1  one-cycle pulse; results valid and updated
overflow  output  1  registered; 1 if the last captured bin_in ≥ 10^DIGITS
bcd_out  output  4*DIGITS  packed BCD; digit k (k=0 is units) at [4k+3:4k]
seg_out  output  7*DIGITS  7-seg, active-low; digit k at [7k+6:7k], bit 7k+6 = seg a … bit 7k = seg g

Behaviour:
- rst low (async): state=IDLE, busy=0, done=0, overflow=0, bcd_out=0, internal shift/count registers cleared.
- Reset value of seg_out shows value 0: digit0 = 0000001 (a..g order). Other digits are blank (1111111) if BLANK_LZ=1, else 0000001.
- States: IDLE, SHIFT.
- IDLE & start=1 at edge E0:
  - capture bin_in into the shift register, clear the BCD accumulator and bit counter → SHIFT.
  - overflow_next = (bin_in ≥ 10^DIGITS); the constant is computed at elaboration with width sufficient for the compare.
- SHIFT, each edge:
  - every BCD digit ≥5 gets +3.
  - then the {BCD, binary} register shifts left by 1; the counter increments.
- On the IN-th SHIFT edge (edge E0+IN):
  - bcd_out, seg_out and overflow are loaded; done=1 for exactly one cycle; state → IDLE.
  - busy is high in the cycles between E0 and E0+IN, i.e. IN cycles. Latency from start edge to done = IN cycles.
- BCD bits shifted out of the top digit are discarded, so bcd_out = bin_in mod 10^DIGITS.
- start while busy=1 is ignored (no queueing). bin_in changes during SHIFT have no effect.
- start=1 in the cycle done=1 is accepted (state is IDLE): back-to-back conversion, done pulses every IN+1 cycles minimum.
- Outputs hold their last value between conversions; they never show intermediate values.
- Segment map (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - codes 10–15 cannot occur; map them to blank.
- Blanking (BLANK_LZ=1, overflow=0): digits above the most significant nonzero digit are blank. Digit0 is never blanked.
- When overflow=1, blanking is disabled and all DIGITS digits are shown (e.g. "023").
- rst asserted mid-conversion: immediate return to reset state. done does not pulse, and outputs return to their reset values.
- All outputs are registered; no combinational path from start/bin_in to any output.

Test Plan:
1. Reset, IN=8, DIGITS=3, BLANK_LZ=1 → bcd_out=12'h000, seg digit0=0000001, digits1–2=1111111, busy=0, done=0.
2. start with bin_in=255 → busy for 8 cycles, done pulse on 8th edge. Then bcd_out=12'h255, seg = 2/5/5 patterns, overflow=0.
3. bin_in=7 → bcd_out=12'h007, digit0=0001111, digits1–2 blank. Then bin_in=100 → 12'h100, no blanking, inner zero shown.
4. IN=10, DIGITS=3, bin_in=1023 → bcd_out=12'h023, overflow=1, digit2 shows 0000001 (not blank). Then bin_in=999 → overflow=0, 12'h999.
5. start held high continuously with bin_in=42 then 99 → one conversion per IN+1 cycles. A start pulse mid-SHIFT does not restart; the second result is 12'h099 with digit2 blank.
6. rst pulsed low 3 cycles after start (bin_in=200) → busy=0 and outputs at reset values immediately, no done. A new start yields 12'h200 after IN cycles.
